// File: rtl/uart_sched_pkg.sv
// ---------------------------------------------------------------------------
// uart_sched_pkg
// Shared definitions for the UART transmit scheduler: the FSM state
// encoding, the default frame gap and watchdog limits, and the byte width
// used for the requester and transmitter data paths.
// ---------------------------------------------------------------------------
package uart_sched_pkg;

    localparam int BYTE_W          = 8;
    localparam int GAP_CYCLES_DEF  = 4;
    localparam int WDOG_CYCLES_DEF = 4096;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_GRANT  = 3'd2,
        ST_LAUNCH = 3'd3,
        ST_SEND   = 3'd4,
        ST_GAP    = 3'd5
    } sched_state_t;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler_if
// Bundles the requester handshake and the transmitter control lines that
// the scheduler sits between.
//   req_valid [NUM_REQ]    requester i has a byte pending
//   req_data  [NUM_REQ*8]  byte of requester i at [8i+7:8i]
//   req_ready [NUM_REQ]    one-cycle accept pulse to requester i
//   Tx_DATA   [8]          byte to the transmitter
//   Tx_WR                  write strobe to the transmitter
//   Tx_EN                  transmitter enable
//   Tx_BUSY                transmitter busy (START..PARITY)
// Modports: master = scheduler side, slave = requesters + transmitter side.
// ---------------------------------------------------------------------------
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    import uart_sched_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*BYTE_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [BYTE_W-1:0]         Tx_DATA;
    logic                      Tx_WR;
    logic                      Tx_EN;
    logic                      Tx_BUSY;

    modport master (
        input  req_valid, req_data, Tx_BUSY,
        output req_ready, Tx_DATA, Tx_WR, Tx_EN
    );

    modport slave (
        output req_valid, req_data, Tx_BUSY,
        input  req_ready, Tx_DATA, Tx_WR, Tx_EN
    );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Searches the valid vector starting one
// position above the pointer and wrapping, so the last winner has the
// lowest priority in the next round.
//   i_valid     [NUM_REQ]  request vector
//   i_ptr       [IDX_W]    index of the previous winner
//   o_win       [IDX_W]    index of the selected requester
//   o_any_valid            at least one request is pending
// ---------------------------------------------------------------------------
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_win,
    output logic               o_any_valid
);

    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // Walk ptr+1, ptr+2, ... ptr+NUM_REQ (mod NUM_REQ); the previous
    // winner itself is visited last, so it only wins when it is alone.
    always_comb begin
        o_win   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
            if (!w_found && i_valid[w_idx]) begin
                w_found = 1'b1;
                o_win   = w_idx;
            end
        end
    end

    assign o_any_valid = |i_valid;

endmodule

// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART transmitter among NUM_REQ byte sources. A round-robin
// arbiter picks a requester, the byte is latched and held on Tx_DATA for
// the whole frame, Tx_WR is strobed until the transmitter reports busy,
// and a fixed idle gap follows every frame so the transmitter can settle.
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   i_sched_en    global enable, 0 parks the transmitter in OFF
//   i_err_clr     clears the sticky watchdog flag
//   o_grant_id    index of the requester owning the current/last frame
//   o_sched_busy  high from grant until the post-frame gap ends
//   o_wdog_err    sticky watchdog abort flag
//   bus           uart_tx_scheduler_if.master (requesters + transmitter)
// Optional feature: define UART_SCHED_WDOG_EN to abort a frame when the
// transmitter fails to complete within WDOG_CYCLES clocks. Without it the
// scheduler waits indefinitely and o_wdog_err is tied low.
// ---------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int IDX_W       = $clog2(NUM_REQ),
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_sched_en,
    input  logic                i_err_clr,
    output logic [IDX_W-1:0]    o_grant_id,
    output logic                o_sched_busy,
    output logic                o_wdog_err,
    uart_tx_scheduler_if.master bus
);

    localparam int GAP_W = $clog2(GAP_CYCLES);

    sched_state_t      r_state;
    sched_state_t      w_next;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_grant_id;
    logic [BYTE_W-1:0] r_tx_data;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [IDX_W-1:0]  w_win;
    logic              w_any_valid;
    logic              w_gap_done;
    logic              w_take;
    logic              w_wdog_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_valid     (bus.req_valid),
        .i_ptr       (r_ptr),
        .o_win       (w_win),
        .o_any_valid (w_any_valid)
    );

    assign w_gap_done = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign w_take     = (r_state == ST_IDLE) && (w_next == ST_GRANT);

    // State register; reset drops straight to OFF so Tx_EN/Tx_WR fall
    // without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. A watchdog hit in LAUNCH or SEND abandons the frame
    // but still passes through GAP so the transmitter sees a quiet period.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_OFF: begin
                if (i_sched_en) w_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (!i_sched_en)      w_next = ST_OFF;
                else if (w_any_valid) w_next = ST_GRANT;
            end
            ST_GRANT: begin
                w_next = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                if (w_wdog_hit)       w_next = ST_GAP;
                else if (bus.Tx_BUSY) w_next = ST_SEND;
            end
            ST_SEND: begin
                if (w_wdog_hit)        w_next = ST_GAP;
                else if (!bus.Tx_BUSY) w_next = ST_GAP;
            end
            ST_GAP: begin
                if (w_gap_done) w_next = i_sched_en ? ST_IDLE : ST_OFF;
            end
            default: begin
                w_next = ST_OFF;
            end
        endcase
    end

    // The winner is captured on the IDLE->GRANT edge, so later changes on
    // req_valid/req_data cannot disturb the byte already promised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_data  <= '0;
            r_grant_id <= '0;
            r_ptr      <= IDX_W'(NUM_REQ - 1);
        end else if (w_take) begin
            r_tx_data  <= bus.req_data[int'(w_win) * BYTE_W +: BYTE_W];
            r_grant_id <= w_win;
            r_ptr      <= w_win;
        end
    end

    // Gap counter only runs inside GAP and restarts from zero each frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap_cnt <= '0;
        end else if (r_state == ST_GAP) begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
        end else begin
            r_gap_cnt <= '0;
        end
    end

`ifdef UART_SCHED_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES);

    logic [WDOG_W-1:0] r_wdog_cnt;
    logic              r_wdog_err;
    logic              w_wait;

    assign w_wait     = (r_state == ST_LAUNCH) || (r_state == ST_SEND);
    assign w_wdog_hit = w_wait && (r_wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

    // Watchdog counts every clock spent waiting on the transmitter,
    // starting fresh at each launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_cnt <= '0;
        end else if (w_wait) begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
        end else begin
            r_wdog_cnt <= '0;
        end
    end

    // Sticky abort flag; a fresh timeout beats a simultaneous clear so an
    // abort is never silently lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_err <= 1'b0;
        end else if (w_wdog_hit) begin
            r_wdog_err <= 1'b1;
        end else if (i_err_clr) begin
            r_wdog_err <= 1'b0;
        end
    end

    assign o_wdog_err = r_wdog_err;
`else
    logic w_unused;

    assign w_wdog_hit = 1'b0;
    assign o_wdog_err = 1'b0;
    assign w_unused   = i_err_clr | (WDOG_CYCLES == 0);
`endif

    // Outputs are decoded from the state register, which the async reset
    // clears, so every one of them goes inactive the moment reset asserts.
    assign bus.Tx_DATA   = r_tx_data;
    assign bus.Tx_WR     = (r_state == ST_LAUNCH);
    assign bus.Tx_EN     = (r_state != ST_OFF);
    assign bus.req_ready = (r_state == ST_GRANT) ? (NUM_REQ'(1) << r_grant_id) : '0;
    assign o_grant_id    = r_grant_id;
    assign o_sched_busy  = (r_state == ST_GRANT) || (r_state == ST_LAUNCH) ||
                           (r_state == ST_SEND)  || (r_state == ST_GAP);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Directed bench for the UART transmit scheduler. The bench plays both the
// requesters and the transmitter, drives and samples on the falling edge,
// and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int NUM_REQ = 4;
    localparam int GAP     = 4;
    localparam int WDOG    = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       schedEn;
    logic       errClr;
    logic [1:0] grantId;
    logic       schedBusy;
    logic       wdogErr;

    int testCount   = 0;
    int failCount   = 0;
    int readyPulses = 0;
    logic [3:0] grantLog[$];

    uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus();

    uart_tx_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .IDX_W       (2),
        .GAP_CYCLES  (GAP),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_sched_en   (schedEn),
        .i_err_clr    (errClr),
        .o_grant_id   (grantId),
        .o_sched_busy (schedBusy),
        .o_wdog_err   (wdogErr),
        .bus          (bus)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Record every accept pulse so grant order and pulse counts can be
    // checked after the fact.
    always @(negedge clk) begin
        if (bus.req_ready != '0) begin
            readyPulses += $countones(bus.req_ready);
            grantLog.push_back(bus.req_ready);
        end
    end

    // Hard stop in case the scheduler wedges somewhere unexpected.
    initial begin
        #500000;
        $display("[TB] FAIL globalTimeout: simulation did not finish, limit reached");
        $fatal(1, "[TB] timeout");
    end

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive requester vector and global enable together.
    task automatic applyStimulus(input logic [3:0] valid, input logic en);
        bus.req_valid = valid;
        schedEn       = en;
    endtask

    // Pulse reset for one cycle; returns in IDLE when the scheduler is enabled.
    task automatic applyReset();
        rst_n         = 1'b0;
        bus.Tx_BUSY   = 1'b0;
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Wait (bounded) for the write strobe.
    task automatic waitTxWr(output bit seen);
        seen = bus.Tx_WR;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = bus.Tx_WR;
        end
    endtask

    // Act as the transmitter for one frame: answer the strobe with busy,
    // hold busy for busyLen clocks and release it. Optionally the granted
    // requester withdraws its request once the strobe appears.
    task automatic serveFrame(input int busyLen, input bit consume,
                              input logic [7:0] expData, input logic [1:0] expGrant);
        bit seen;
        logic [3:0] won;
        waitTxWr(seen);
        checkOutput("txWrSeen", 32'(seen), 32'd1);
        if (seen) begin
            won = (grantLog.size() > 0) ? grantLog[grantLog.size() - 1] : 4'h0;
            if (consume) bus.req_valid = bus.req_valid & ~won;
            @(negedge clk);
            checkOutput("txWrHeld", 32'(bus.Tx_WR), 32'd1);
            bus.Tx_BUSY = 1'b1;
            @(negedge clk);
            checkOutput("txWrDrop", 32'(bus.Tx_WR), 32'd0);
            repeat (busyLen) @(negedge clk);
            checkOutput("frameData", 32'(bus.Tx_DATA), 32'(expData));
            checkOutput("frameGrant", 32'(grantId), 32'(expGrant));
            bus.Tx_BUSY = 1'b0;
        end
    endtask

    // Clocks between busy falling and the next strobe rising.
    task automatic countGap(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.Tx_WR) break;
            n++;
        end
    endtask

    // Main directed sequence.
    initial begin
        bit   seen;
        int   n;
        int   p;
        logic [7:0] dataB[4];
        logic [3:0] orderB[5];

        dataB  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        orderB = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst_n        = 1'b0;
        errClr       = 1'b0;
        bus.req_data = '0;
        bus.Tx_BUSY  = 1'b0;
        applyStimulus(4'b0000, 1'b0);
        repeat (2) @(negedge clk);

        // Reset values.
        checkOutput("rstTxEn", 32'(bus.Tx_EN), 32'd0);
        checkOutput("rstTxWr", 32'(bus.Tx_WR), 32'd0);
        checkOutput("rstBusy", 32'(schedBusy), 32'd0);
        checkOutput("rstGrant", 32'(grantId), 32'd0);
        checkOutput("rstData", 32'(bus.Tx_DATA), 32'd0);
        checkOutput("rstReady", 32'(bus.req_ready), 32'd0);
        checkOutput("rstWdog", 32'(wdogErr), 32'd0);

        // Disabled scheduler stays OFF; enabling it brings Tx_EN up.
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("offTxEn", 32'(bus.Tx_EN), 32'd0);
        schedEn = 1'b1;
        @(negedge clk);
        checkOutput("idleTxEn", 32'(bus.Tx_EN), 32'd1);
        checkOutput("idleBusy", 32'(schedBusy), 32'd0);

        // Single requester 0 with byte A5: cycle-by-cycle handshake.
        bus.req_data = {8'h44, 8'h33, 8'h22, 8'hA5};
        applyStimulus(4'b0001, 1'b1);
        @(negedge clk);
        checkOutput("aReady", 32'(bus.req_ready), 32'h1);
        checkOutput("aBusyGrant", 32'(schedBusy), 32'd1);
        checkOutput("aWrInGrant", 32'(bus.Tx_WR), 32'd0);
        bus.req_valid = '0;
        @(negedge clk);
        checkOutput("aWrLaunch", 32'(bus.Tx_WR), 32'd1);
        checkOutput("aDataLaunch", 32'(bus.Tx_DATA), 32'hA5);
        checkOutput("aReadyDone", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        checkOutput("aWrHeld", 32'(bus.Tx_WR), 32'd1);
        bus.Tx_BUSY = 1'b1;
        @(negedge clk);
        checkOutput("aWrDrop", 32'(bus.Tx_WR), 32'd0);
        bus.req_data[7:0] = 8'h5A;
        repeat (3) @(negedge clk);
        checkOutput("aDataStable", 32'(bus.Tx_DATA), 32'hA5);
        bus.Tx_BUSY = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!schedBusy) break;
            n++;
        end
        checkOutput("aGapLen", 32'(n), 32'(GAP));
        checkOutput("aPulses", 32'(readyPulses), 32'd1);

        // All four requesters continuously valid: rotation 0,1,2,3,0. The
        // strobe-to-strobe idle time is the gap plus the IDLE and GRANT clocks.
        applyReset();
        grantLog.delete();
        bus.req_data = {dataB[3], dataB[2], dataB[1], dataB[0]};
        applyStimulus(4'b1111, 1'b1);
        for (int k = 0; k < 5; k++) begin
            serveFrame(2, 1'b0, dataB[k % 4], 2'(k % 4));
            if (k == 4) begin
                bus.req_valid = '0;
            end else begin
                countGap(n);
                checkOutput("bGapIdle", 32'(n), 32'(GAP + 2));
            end
        end
        repeat (10) @(negedge clk);
        checkOutput("bLogSize", 32'(grantLog.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            checkOutput("bOrder", 32'((grantLog.size() > k) ? grantLog[k] : 4'h0),
                        32'(orderB[k]));
        end
        checkOutput("bWdogClear", 32'(wdogErr), 32'd0);

        // Pointer at 1 with requesters 1 and 3 pending: 3 wins, then 1.
        applyReset();
        grantLog.delete();
        bus.req_data = {8'h3C, 8'h2B, 8'h1A, 8'h09};
        applyStimulus(4'b0010, 1'b1);
        serveFrame(1, 1'b1, 8'h1A, 2'd1);
        bus.req_valid = 4'b1010;
        serveFrame(1, 1'b1, 8'h3C, 2'd3);
        serveFrame(1, 1'b1, 8'h1A, 2'd1);
        repeat (8) @(negedge clk);
        checkOutput("cLogSize", 32'(grantLog.size()), 32'd3);
        checkOutput("cFirst", 32'((grantLog.size() > 1) ? grantLog[1] : 4'h0), 32'b1000);
        checkOutput("cSecond", 32'((grantLog.size() > 2) ? grantLog[2] : 4'h0), 32'b0010);

        // Enable dropped during SEND: frame ends, gap runs with Tx_EN high,
        // then OFF with no further grants despite a pending request.
        applyStimulus(4'b0001, 1'b1);
        waitTxWr(seen);
        checkOutput("dWrSeen", 32'(seen), 32'd1);
        @(negedge clk);
        bus.Tx_BUSY = 1'b1;
        @(negedge clk);
        schedEn = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("dDataSend", 32'(bus.Tx_DATA), 32'h09);
        bus.Tx_BUSY = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.Tx_EN) break;
            n++;
        end
        checkOutput("dEnHold", 32'(n), 32'(GAP));
        p = readyPulses;
        repeat (10) @(negedge clk);
        checkOutput("dNoGrant", 32'(readyPulses), 32'(p));
        checkOutput("dTxEnOff", 32'(bus.Tx_EN), 32'd0);
        checkOutput("dBusyOff", 32'(schedBusy), 32'd0);
        schedEn = 1'b1;
        serveFrame(1, 1'b1, 8'h09, 2'd0);
        repeat (8) @(negedge clk);

        // Async reset in the middle of SEND, then requester 0 wins first.
        grantLog.delete();
        applyStimulus(4'b0100, 1'b1);
        waitTxWr(seen);
        checkOutput("eWrSeen", 32'(seen), 32'd1);
        bus.req_valid = '0;
        @(negedge clk);
        bus.Tx_BUSY = 1'b1;
        @(negedge clk);
        checkOutput("eEnBefore", 32'(bus.Tx_EN), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("eRstWr", 32'(bus.Tx_WR), 32'd0);
        checkOutput("eRstEn", 32'(bus.Tx_EN), 32'd0);
        checkOutput("eRstBusy", 32'(schedBusy), 32'd0);
        checkOutput("eRstData", 32'(bus.Tx_DATA), 32'd0);
        @(negedge clk);
        bus.Tx_BUSY = 1'b0;
        grantLog.delete();
        bus.req_valid = 4'b0101;
        rst_n = 1'b1;
        serveFrame(1, 1'b1, 8'h09, 2'd0);
        serveFrame(1, 1'b1, 8'h2B, 2'd2);
        repeat (8) @(negedge clk);
        checkOutput("eLogSize", 32'(grantLog.size()), 32'd2);
        checkOutput("eFirstReq0", 32'((grantLog.size() > 0) ? grantLog[0] : 4'h0), 32'b0001);

`ifdef UART_SCHED_WDOG_EN
        // Transmitter never answers: strobe lasts WDOG clocks, then abort.
        applyStimulus(4'b0001, 1'b1);
        waitTxWr(seen);
        checkOutput("fWrSeen", 32'(seen), 32'd1);
        bus.req_valid = '0;
        n = seen ? 1 : 0;
        for (int i = 0; i < 40 && seen; i++) begin
            @(negedge clk);
            if (!bus.Tx_WR) break;
            n++;
        end
        checkOutput("fWdogLen", 32'(n), 32'(WDOG));
        checkOutput("fWdogErr", 32'(wdogErr), 32'd1);
        checkOutput("fBusyGap", 32'(schedBusy), 32'd1);
        errClr = 1'b1;
        @(negedge clk);
        errClr = 1'b0;
        checkOutput("fWdogClr", 32'(wdogErr), 32'd0);
        repeat (8) @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
